// File: rtl/prover_compute_v_sched_pkg.sv
// Shared types and helpers for the compute_v round scheduler.
package prover_compute_v_pkg;

  // Scheduler states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } sched_state_e;

  // Round-index width: enough bits for n rounds, never less than one.
  function automatic int rw_of(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/prover_compute_v_sched_collect.sv
// Per-lane sticky completion collector.
// Each unit's pulse sets its own bit; a lane is done when every bit of it is set.
// Also reports whether any pulse is present and whether any pulse hits a bit
// that was already collected this round.
module prover_compute_v_sched_collect #(
  parameter int ninputs   = 8,
  parameter int nParallel = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coll_en,
  input  logic                 coll_clr,
  input  logic [nParallel-1:0] en_in [ninputs-1:0],
  output logic [nParallel-1:0] lane_done,
  output logic                 dup_hit,
  output logic                 any_pulse
);

  logic [nParallel-1:0][ninputs-1:0] coll_q;
  logic [nParallel-1:0][ninputs-1:0] coll_d;

  // Next collect state: clear wins over merge, so a pulse in the clear cycle is dropped.
  always_comb begin
    coll_d    = coll_q;
    dup_hit   = 1'b0;
    any_pulse = 1'b0;
    for (int p = 0; p < nParallel; p++) begin
      for (int i = 0; i < ninputs; i++) begin
        any_pulse = any_pulse | en_in[i][p];
        dup_hit   = dup_hit | (en_in[i][p] & coll_q[p][i]);
        if (coll_clr) begin
          coll_d[p][i] = 1'b0;
        end else if (coll_en) begin
          coll_d[p][i] = coll_q[p][i] | en_in[i][p];
        end else begin
          coll_d[p][i] = coll_q[p][i];
        end
      end
    end
  end

  // A lane is complete once all of its units have reported.
  always_comb begin
    lane_done = '0;
    for (int p = 0; p < nParallel; p++) begin
      lane_done[p] = &coll_q[p];
    end
  end

  // Collect register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_q <= '0;
    end else begin
      coll_q <= coll_d;
    end
  end

endmodule

// File: rtl/prover_compute_v_sched.sv
// Round scheduler for the prover compute_v stage.
// Launches a round on all lanes, waits for every unit to report and for the
// downstream consumer to be ready, then retires the round; repeats nRounds times.
module prover_compute_v_sched
  import prover_compute_v_pkg::*;
#(
  parameter int ninputs   = 8,
  parameter int nParallel = 4,
  parameter int nRounds   = 16,
  localparam int RW       = rw_of(nRounds)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ds_ready,
  input  logic [nParallel-1:0] en_in [ninputs-1:0],
  output logic [nParallel-1:0] go_out,
  output logic [nParallel-1:0] lane_done,
  output logic                 round_done,
  output logic [RW-1:0]        round_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  sched_state_e state_q, state_d;
  logic [RW-1:0] round_idx_q, round_idx_d;
  logic          err_q, err_d;

  logic coll_en;
  logic adv;
  logic last_round;
  logic start_acc;
  logic dup_hit;
  logic any_pulse;
  logic err_event;

  assign coll_en    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign adv        = (state_q == ST_WAIT) && (&lane_done) && ds_ready;
  assign last_round = (round_idx_q == RW'(nRounds - 1));
  assign start_acc  = (state_q == ST_IDLE) && start;

  prover_compute_v_sched_collect #(
    .ninputs  (ninputs),
    .nParallel(nParallel)
  ) u_collect (
    .clk      (clk),
    .rst      (rst),
    .coll_en  (coll_en),
    .coll_clr (adv),
    .en_in    (en_in),
    .lane_done(lane_done),
    .dup_hit  (dup_hit),
    .any_pulse(any_pulse)
  );

  // Protocol errors: repeated pulse, pulse outside a round, or pulse in the retire cycle.
  assign err_event = (coll_en & dup_hit) | (~coll_en & any_pulse) | (adv & any_pulse);

  // Next-state, round counter and sticky error.
  always_comb begin
    state_d     = state_q;
    round_idx_d = round_idx_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_ISSUE;
          round_idx_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (adv && last_round) begin
          state_d = ST_FIN;
        end else if (adv) begin
          state_d     = ST_ISSUE;
          round_idx_d = round_idx_q + RW'(1);
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // An accepted start wipes history; an error in that same cycle still counts.
    if (start_acc) begin
      err_d = err_event;
    end else begin
      err_d = err_q | err_event;
    end
  end

  // State, round index and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      round_idx_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      err_q       <= err_d;
    end
  end

  assign go_out     = {nParallel{state_q == ST_ISSUE}};
  assign round_done = adv;
  assign round_idx  = round_idx_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);
  assign err        = err_q;

endmodule

// File: tb/tb_prover_compute_v_sched.sv
// Scoreboard bench for prover_compute_v_sched: a default build (16 rounds) and a
// single-round build share clock and reset.
module tb_prover_compute_v_sched;

  localparam int NI = 8;
  localparam int NP = 4;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          start_a = 1'b0;
  logic          ds_ready_a = 1'b1;
  logic [NP-1:0] en_a [NI-1:0];
  logic [NP-1:0] go_a, lane_done_a;
  logic          round_done_a, busy_a, done_a, err_a;
  logic [3:0]    round_idx_a;

  logic          start_b = 1'b0;
  logic          ds_ready_b = 1'b1;
  logic [NP-1:0] en_b [NI-1:0];
  logic [NP-1:0] go_b, lane_done_b;
  logic          round_done_b, busy_b, done_b, err_b;
  logic [0:0]    round_idx_b;

  always #5 clk = ~clk;

  prover_compute_v_sched #(.ninputs(NI), .nParallel(NP), .nRounds(NR)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ds_ready(ds_ready_a), .en_in(en_a),
    .go_out(go_a), .lane_done(lane_done_a), .round_done(round_done_a),
    .round_idx(round_idx_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  prover_compute_v_sched #(.ninputs(NI), .nParallel(NP), .nRounds(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ds_ready(ds_ready_b), .en_in(en_b),
    .go_out(go_b), .lane_done(lane_done_b), .round_done(round_done_b),
    .round_idx(round_idx_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  // Expected event stream: kind 0 = go_out, 1 = round_done, 2 = done.
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] idx;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input int idx);
    ev_t e;
    e.kind = k;
    e.idx  = 4'(idx);
    exp_q.push_back(e);
  endtask

  // Monitor: every output event of the 16-round build is matched against the queue.
  always @(negedge clk) begin : monitor
    logic [1:0] k;
    ev_t        e;
    if (!rst && (go_a != 4'h0 || round_done_a || done_a)) begin
      k = round_done_a ? 2'd1 : (done_a ? 2'd2 : 2'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: event kind %0d idx %0d, expected no event", k, round_idx_a);
      end else begin
        e = exp_q.pop_front();
        check("sb_kind", 32'(k), 32'(e.kind));
        check("sb_idx", 32'(round_idx_a), 32'(e.idx));
        if (k == 2'd0) check("sb_go_all", 32'(go_a), 32'h0000_000F);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en_a(input logic [NP-1:0] v);
    for (int i = 0; i < NI; i++) en_a[i] = v;
  endtask

  task automatic pulse_all_a();
    set_en_a(4'hF);
    tick();
    set_en_a(4'h0);
  endtask

  // Start a job; on return we are in the first go_out cycle.
  task automatic start_job_a();
    push_ev(2'd0, 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("start_latency_go", 32'(go_a), 32'h0000_000F);
  endtask

  // Units pulse 3 cycles after go_out; ends in the next go_out (or done) cycle.
  task automatic nominal_round(input int r, input logic poke);
    tick();
    start_a = poke;
    tick();
    start_a = 1'b0;
    tick();
    push_ev(2'd1, r);
    if (r == NR - 1) push_ev(2'd2, r);
    else push_ev(2'd0, r + 1);
    pulse_all_a();
    check("rd_latency", 32'(round_done_a), 32'd1);
    tick();
    if (r == NR - 1) begin
      check("done_latency", 32'(done_a), 32'd1);
      start_a = poke;
      tick();
      start_a = 1'b0;
      check("idle_after_done", 32'(busy_a), 32'd0);
    end else begin
      check("next_go_latency", 32'(go_a), 32'h0000_000F);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_en_a(4'h0);
    for (int i = 0; i < NI; i++) en_b[i] = 4'h0;

    // Reset state.
    @(negedge clk);
    check("rst_go", 32'(go_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_idx", 32'(round_idx_a), 32'd0);
    check("rst_lane_done", 32'(lane_done_a), 32'd0);
    check("rst_err_done", 32'({err_a, done_a, round_done_a}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Job 1: nominal, 16 rounds.
    start_job_a();
    for (int r = 0; r < NR; r++) nominal_round(r, 1'b0);
    check("job1_err", 32'(err_a), 32'd0);
    check("job1_idx_hold", 32'(round_idx_a), 32'd15);

    // Job 2: staggered, backpressure, duplicate, then nominal.
    start_job_a();
    // Round 0: lane 2 unit 7 arrives 10 cycles late.
    repeat (3) tick();
    set_en_a(4'hF);
    en_a[7] = 4'b1011;
    tick();
    set_en_a(4'h0);
    for (int j = 0; j < 9; j++) begin
      check("stagger_lane_done", 32'(lane_done_a), 32'h0000_000B);
      check("stagger_no_rd", 32'(round_done_a), 32'd0);
      tick();
    end
    push_ev(2'd1, 0);
    push_ev(2'd0, 1);
    en_a[7] = 4'b0100;
    tick();
    en_a[7] = 4'b0000;
    check("stagger_rd", 32'(round_done_a), 32'd1);
    tick();
    // Round 1: everything complete while ds_ready is low.
    repeat (3) tick();
    ds_ready_a = 1'b0;
    pulse_all_a();
    for (int j = 0; j < 5; j++) begin
      check("bp_lane_done", 32'(lane_done_a), 32'h0000_000F);
      check("bp_no_rd", 32'(round_done_a), 32'd0);
      tick();
    end
    push_ev(2'd1, 1);
    push_ev(2'd0, 2);
    ds_ready_a = 1'b1;
    #1;
    check("bp_release_rd", 32'(round_done_a), 32'd1);
    tick();
    check("bp_next_go", 32'(go_a), 32'h0000_000F);
    // Round 2: lane 0 unit 3 pulses twice.
    tick();
    en_a[3] = 4'b0001;
    tick();
    en_a[3] = 4'b0000;
    check("dup_first_ok", 32'(err_a), 32'd0);
    en_a[3] = 4'b0001;
    tick();
    en_a[3] = 4'b0000;
    check("dup_err", 32'(err_a), 32'd1);
    push_ev(2'd1, 2);
    push_ev(2'd0, 3);
    set_en_a(4'hF);
    en_a[3] = 4'b1110;
    tick();
    set_en_a(4'h0);
    check("dup_rd", 32'(round_done_a), 32'd1);
    tick();
    for (int r = 3; r < NR; r++) nominal_round(r, 1'b0);
    check("err_sticky", 32'(err_a), 32'd1);

    // Job 3: err clears on start; reset during round 5 WAIT.
    start_job_a();
    check("err_clear_on_start", 32'(err_a), 32'd0);
    for (int r = 0; r < 5; r++) nominal_round(r, 1'b0);
    tick();
    set_en_a(4'b0001);
    tick();
    set_en_a(4'h0);
    check("pre_rst_lane_done", 32'(lane_done_a), 32'h0000_0001);
    check("pre_rst_idx", 32'(round_idx_a), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy_a), 32'd0);
    check("async_rst_idx", 32'(round_idx_a), 32'd0);
    check("async_rst_lane_done", 32'(lane_done_a), 32'd0);
    check("async_rst_go", 32'(go_a), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_no_pending", 32'(exp_q.size()), 32'd0);

    // Job 4: fresh job with start poked while busy.
    start_job_a();
    check("fresh_idx", 32'(round_idx_a), 32'd0);
    for (int r = 0; r < NR; r++) nominal_round(r, 1'b1);
    check("job4_err", 32'(err_a), 32'd0);
    // Pulse while idle is a protocol error.
    en_a[0] = 4'b0001;
    tick();
    en_a[0] = 4'b0000;
    check("err_idle_pulse", 32'(err_a), 32'd1);

    // Single-round build.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("r1_go", 32'(go_b), 32'h0000_000F);
    check("r1_idx", 32'(round_idx_b), 32'd0);
    tick();
    for (int i = 0; i < NI; i++) en_b[i] = 4'hF;
    tick();
    for (int i = 0; i < NI; i++) en_b[i] = 4'h0;
    check("r1_rd", 32'(round_done_b), 32'd1);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("r1_done", 32'(done_b), 32'd1);
    check("r1_idx_final", 32'(round_idx_b), 32'd0);
    tick();
    check("r1_idle", 32'({busy_b, done_b, go_b}), 32'd0);
    tick();
    check("r1_single_done", 32'({busy_b, done_b}), 32'd0);
    check("r1_err", 32'(err_b), 32'd0);

    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
